pcie_lite_requester: RTL and testbench

//  Requester (initiator) end of the pcie_lite TLP/completion interface. Turns user read/write

---
 rtl/pcie_lite_requester.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_pcie_lite_requester.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_lite_requester.sv
// pcie_lite_requester
//
// Requester end of the pcie_lite TLP/completion interface. User read/write commands become
// single-DW MRd/MWr TLPs held in a one-entry TLP register. Reads allocate the lowest free tag,
// and a per-tag 16-bit timer starts once the MRd has been handed to the endpoint. Returning
// CplD completions are matched against busy tags and forwarded through a one-entry response
// register. A tag whose timer runs out is reported locally with status TIMEOUT (3'b100).
// Completions that match no busy tag are dropped and counted.
//
// Ports
//   clk_i, rst_i              clock and synchronous active-high reset
//   link_up_i                 link status; new commands are accepted only while high
//   req_*                     user command channel (valid/ready, write flag, addr, wdata)
//   tlp_*                     TLP channel to the endpoint (valid/ready, type, addr, data,
//                             tag, length)
//   cpl_*                     completion channel from the endpoint (valid/ready, status,
//                             data, tag)
//   rsp_*                     read response channel to the user (valid/ready, tag, data,
//                             status)
//   outstanding_o             number of busy tags
//   err_unexp_cpl_o           one-cycle pulse when an unexpected completion is dropped
//   unexp_cnt_o               saturating count of unexpected completions

module pcie_lite_requester #(
  parameter int unsigned NUM_TAGS    = 4,
  parameter int unsigned CPL_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        link_up_i,
  // user command
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  // TLP to endpoint
  output logic        tlp_valid_o,
  input  logic        tlp_ready_i,
  output logic [2:0]  tlp_type_o,
  output logic [31:0] tlp_address_o,
  output logic [31:0] tlp_data_o,
  output logic [7:0]  tlp_tag_o,
  output logic [9:0]  tlp_length_o,
  // completion from endpoint
  input  logic        cpl_valid_i,
  output logic        cpl_ready_o,
  input  logic [2:0]  cpl_status_i,
  input  logic [31:0] cpl_data_i,
  input  logic [7:0]  cpl_tag_i,
  // response to user
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [7:0]  rsp_tag_o,
  output logic [31:0] rsp_data_o,
  output logic [2:0]  rsp_status_o,
  // accounting
  output logic [4:0]  outstanding_o,
  output logic        err_unexp_cpl_o,
  output logic [7:0]  unexp_cnt_o
);

  localparam int unsigned TagW       = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam logic [15:0] TimeoutVal = 16'(CPL_TIMEOUT);
  localparam logic [2:0]  TypeMrd    = 3'b000;
  localparam logic [2:0]  TypeMwr    = 3'b001;
  localparam logic [2:0]  StTimeout  = 3'b100;

  // ---------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------
  // Tag table
  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [NUM_TAGS-1:0] sent_q, sent_d;   // MRd for this tag has left the TLP register
  logic [15:0]         timer_q [NUM_TAGS];
  logic [15:0]         timer_d [NUM_TAGS];

  // TLP register
  logic        tlp_valid_q, tlp_valid_d;
  logic [2:0]  tlp_type_q, tlp_type_d;
  logic [31:0] tlp_addr_q, tlp_addr_d;
  logic [31:0] tlp_data_q, tlp_data_d;
  logic [7:0]  tlp_tag_q, tlp_tag_d;
  logic [9:0]  tlp_len_q, tlp_len_d;

  // Response register
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_tag_q, rsp_tag_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [2:0]  rsp_status_q, rsp_status_d;

  // Accounting
  logic [4:0]  outstanding_q, outstanding_d;
  logic        err_q, err_d;
  logic [7:0]  unexp_cnt_q, unexp_cnt_d;

  // ---------------------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------------------
  logic            free_any;
  logic [TagW-1:0] free_idx;
  logic            exp_any;
  logic [TagW-1:0] exp_idx;
  logic            cpl_hit;
  logic [TagW-1:0] cpl_idx;
  logic            req_acc;
  logic            tlp_hs;
  logic            cpl_rdy;
  logic            cpl_acc;
  logic            timeout_fire;
  logic            alloc;
  logic            release_en;
  logic [TagW-1:0] release_idx;

  // Lowest free tag, lowest expired tag, and completion tag lookup.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    exp_any  = 1'b0;
    exp_idx  = '0;
    cpl_hit  = 1'b0;
    cpl_idx  = '0;
    // Scanning downward leaves the lowest matching index in the result.
    for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_any = 1'b1;
        free_idx = TagW'(i);
      end
      if (busy_q[i] && (timer_q[i] == 16'd0)) begin
        exp_any = 1'b1;
        exp_idx = TagW'(i);
      end
      // Tags at or above NUM_TAGS never match, so they fall through as unexpected.
      if (busy_q[i] && (cpl_tag_i == 8'(i))) begin
        cpl_hit = 1'b1;
        cpl_idx = TagW'(i);
      end
    end
  end

  always_comb begin
    req_ready_o  = link_up_i && !tlp_valid_q && (req_write_i || free_any);
    req_acc      = req_valid_i && req_ready_o;
    alloc        = req_acc && !req_write_i;
    tlp_hs       = tlp_valid_q && tlp_ready_i;
    cpl_rdy      = !rsp_valid_q || rsp_ready_i;
    cpl_acc      = cpl_valid_i && cpl_rdy;
    // A timeout only reports in a cycle with no completion accepted, so completions win.
    timeout_fire = cpl_rdy && !cpl_acc && exp_any;
    release_en   = (cpl_acc && cpl_hit) || timeout_fire;
    release_idx  = (cpl_acc && cpl_hit) ? cpl_idx : exp_idx;
  end

  // ---------------------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------------------
  always_comb begin
    busy_d  = busy_q;
    sent_d  = sent_q;
    timer_d = timer_q;

    // Timers hold until the MRd has been handed off, then count down to zero.
    for (int i = 0; i < int'(NUM_TAGS); i++) begin
      if (busy_q[i] && sent_q[i] && (timer_q[i] != 16'd0)) begin
        timer_d[i] = timer_q[i] - 16'd1;
      end
    end

    if (tlp_hs && (tlp_type_q == TypeMrd)) begin
      sent_d[tlp_tag_q[TagW-1:0]] = 1'b1;
    end

    if (release_en) begin
      busy_d[release_idx] = 1'b0;
      sent_d[release_idx] = 1'b0;
    end

    // Allocation only picks a tag that is not busy, so it never collides with release.
    if (alloc) begin
      busy_d[free_idx]  = 1'b1;
      sent_d[free_idx]  = 1'b0;
      timer_d[free_idx] = TimeoutVal;
    end
  end

  always_comb begin
    tlp_valid_d = tlp_valid_q;
    tlp_type_d  = tlp_type_q;
    tlp_addr_d  = tlp_addr_q;
    tlp_data_d  = tlp_data_q;
    tlp_tag_d   = tlp_tag_q;
    tlp_len_d   = tlp_len_q;
    if (req_acc) begin
      tlp_valid_d = 1'b1;
      tlp_type_d  = req_write_i ? TypeMwr : TypeMrd;
      tlp_addr_d  = req_addr_i;
      tlp_data_d  = req_write_i ? req_wdata_i : 32'd0;
      tlp_tag_d   = req_write_i ? 8'd0 : 8'(free_idx);
      tlp_len_d   = 10'd1;
    end else if (tlp_hs) begin
      tlp_valid_d = 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    if (cpl_acc && cpl_hit) begin
      rsp_valid_d  = 1'b1;
      rsp_tag_d    = cpl_tag_i;
      rsp_data_d   = cpl_data_i;
      rsp_status_d = cpl_status_i;
    end else if (timeout_fire) begin
      rsp_valid_d  = 1'b1;
      rsp_tag_d    = 8'(exp_idx);
      rsp_data_d   = 32'd0;
      rsp_status_d = StTimeout;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_comb begin
    outstanding_d = outstanding_q + {4'd0, alloc} - {4'd0, release_en};
    err_d         = cpl_acc && !cpl_hit;
    unexp_cnt_d   = unexp_cnt_q;
    if (err_d && (unexp_cnt_q != 8'hFF)) begin
      unexp_cnt_d = unexp_cnt_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q        <= '0;
      sent_q        <= '0;
      timer_q       <= '{default: '0};
      tlp_valid_q   <= 1'b0;
      tlp_type_q    <= '0;
      tlp_addr_q    <= '0;
      tlp_data_q    <= '0;
      tlp_tag_q     <= '0;
      tlp_len_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_tag_q     <= '0;
      rsp_data_q    <= '0;
      rsp_status_q  <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      unexp_cnt_q   <= '0;
    end else begin
      busy_q        <= busy_d;
      sent_q        <= sent_d;
      timer_q       <= timer_d;
      tlp_valid_q   <= tlp_valid_d;
      tlp_type_q    <= tlp_type_d;
      tlp_addr_q    <= tlp_addr_d;
      tlp_data_q    <= tlp_data_d;
      tlp_tag_q     <= tlp_tag_d;
      tlp_len_q     <= tlp_len_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_data_q    <= rsp_data_d;
      rsp_status_q  <= rsp_status_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      unexp_cnt_q   <= unexp_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------
  assign tlp_valid_o     = tlp_valid_q;
  assign tlp_type_o      = tlp_type_q;
  assign tlp_address_o   = tlp_addr_q;
  assign tlp_data_o      = tlp_data_q;
  assign tlp_tag_o       = tlp_tag_q;
  assign tlp_length_o    = tlp_len_q;
  assign cpl_ready_o     = cpl_rdy;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_tag_o       = rsp_tag_q;
  assign rsp_data_o      = rsp_data_q;
  assign rsp_status_o    = rsp_status_q;
  assign outstanding_o   = outstanding_q;
  assign err_unexp_cpl_o = err_q;
  assign unexp_cnt_o     = unexp_cnt_q;

endmodule

// File: tb/tb_pcie_lite_requester.sv
// Directed bench for pcie_lite_requester. Two instances share all inputs: dut_a runs with
// the default 1024-cycle timeout, dut_b with a 16-cycle timeout for the timeout scenarios.
// Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.

module tb_pcie_lite_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        link_up;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        tlp_ready;
  logic        cpl_valid;
  logic [2:0]  cpl_status;
  logic [31:0] cpl_data;
  logic [7:0]  cpl_tag;
  logic        rsp_ready;

  logic        a_req_ready, a_tlp_valid, a_cpl_ready, a_rsp_valid, a_err;
  logic [2:0]  a_tlp_type, a_rsp_status;
  logic [31:0] a_tlp_address, a_tlp_data, a_rsp_data;
  logic [7:0]  a_tlp_tag, a_rsp_tag, a_unexp_cnt;
  logic [9:0]  a_tlp_length;
  logic [4:0]  a_outstanding;

  logic        b_req_ready, b_tlp_valid, b_cpl_ready, b_rsp_valid, b_err;
  logic [2:0]  b_tlp_type, b_rsp_status;
  logic [31:0] b_tlp_address, b_tlp_data, b_rsp_data;
  logic [7:0]  b_tlp_tag, b_rsp_tag, b_unexp_cnt;
  logic [9:0]  b_tlp_length;
  logic [4:0]  b_outstanding;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pcie_lite_requester #(.NUM_TAGS(4), .CPL_TIMEOUT(1024)) dut_a (
    .clk_i(clk), .rst_i(rst), .link_up_i(link_up),
    .req_valid_i(req_valid), .req_ready_o(a_req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .tlp_valid_o(a_tlp_valid), .tlp_ready_i(tlp_ready), .tlp_type_o(a_tlp_type),
    .tlp_address_o(a_tlp_address), .tlp_data_o(a_tlp_data), .tlp_tag_o(a_tlp_tag),
    .tlp_length_o(a_tlp_length),
    .cpl_valid_i(cpl_valid), .cpl_ready_o(a_cpl_ready), .cpl_status_i(cpl_status),
    .cpl_data_i(cpl_data), .cpl_tag_i(cpl_tag),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_tag_o(a_rsp_tag),
    .rsp_data_o(a_rsp_data), .rsp_status_o(a_rsp_status),
    .outstanding_o(a_outstanding), .err_unexp_cpl_o(a_err), .unexp_cnt_o(a_unexp_cnt)
  );

  pcie_lite_requester #(.NUM_TAGS(4), .CPL_TIMEOUT(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .link_up_i(link_up),
    .req_valid_i(req_valid), .req_ready_o(b_req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .tlp_valid_o(b_tlp_valid), .tlp_ready_i(tlp_ready), .tlp_type_o(b_tlp_type),
    .tlp_address_o(b_tlp_address), .tlp_data_o(b_tlp_data), .tlp_tag_o(b_tlp_tag),
    .tlp_length_o(b_tlp_length),
    .cpl_valid_i(cpl_valid), .cpl_ready_o(b_cpl_ready), .cpl_status_i(cpl_status),
    .cpl_data_i(cpl_data), .cpl_tag_i(cpl_tag),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_tag_o(b_rsp_tag),
    .rsp_data_o(b_rsp_data), .rsp_status_o(b_rsp_status),
    .outstanding_o(b_outstanding), .err_unexp_cpl_o(b_err), .unexp_cnt_o(b_unexp_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    tlp_ready = 1'b0;
    cpl_valid = 1'b0;
    rsp_ready = 1'b0;
    link_up   = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; link_up = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; tlp_ready = 1'b0; cpl_valid = 1'b0;
    cpl_status = '0; cpl_data = '0; cpl_tag = '0; rsp_ready = 1'b0;
    cyc(); cyc();
    smp();
    chk("reset tlp_valid", 32'(a_tlp_valid), 32'd0);
    chk("reset tlp_length", 32'(a_tlp_length), 32'd0);
    chk("reset rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("reset outstanding", 32'(a_outstanding), 32'd0);
    chk("reset unexp_cnt", 32'(a_unexp_cnt), 32'd0);
    cyc();
    rst = 1'b0;

    // ---- 1: write then read ----
    req(1'b1, 32'h10, 32'hDEADBEEF);
    smp(); chk("t1 wr req_ready", 32'(a_req_ready), 32'd1);
    cyc(); req_valid = 1'b0;
    smp();
    chk("t1 wr tlp_valid", 32'(a_tlp_valid), 32'd1);
    chk("t1 wr type", 32'(a_tlp_type), 32'd1);
    chk("t1 wr tag", 32'(a_tlp_tag), 32'd0);
    chk("t1 wr len", 32'(a_tlp_length), 32'd1);
    chk("t1 wr addr", a_tlp_address, 32'h10);
    chk("t1 wr data", a_tlp_data, 32'hDEADBEEF);
    chk("t1 wr req_ready busy", 32'(a_req_ready), 32'd0);
    tlp_ready = 1'b1; cyc(); tlp_ready = 1'b0;
    smp(); chk("t1 tlp cleared", 32'(a_tlp_valid), 32'd0);
    cyc();
    req(1'b0, 32'h10, 32'h0);
    smp(); chk("t1 rd req_ready", 32'(a_req_ready), 32'd1);
    cyc(); req_valid = 1'b0;
    smp();
    chk("t1 rd type", 32'(a_tlp_type), 32'd0);
    chk("t1 rd tag", 32'(a_tlp_tag), 32'd0);
    chk("t1 rd data", a_tlp_data, 32'd0);
    chk("t1 outstanding 1", 32'(a_outstanding), 32'd1);
    tlp_ready = 1'b1; cyc(); tlp_ready = 1'b0;
    cpl_valid = 1'b1; cpl_tag = 8'd0; cpl_status = 3'b000; cpl_data = 32'hDEADBEEF;
    smp(); chk("t1 cpl_ready", 32'(a_cpl_ready), 32'd1);
    cyc(); cpl_valid = 1'b0;
    smp();
    chk("t1 rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("t1 rsp_tag", 32'(a_rsp_tag), 32'd0);
    chk("t1 rsp_data", a_rsp_data, 32'hDEADBEEF);
    chk("t1 rsp_status", 32'(a_rsp_status), 32'd0);
    chk("t1 outstanding 0", 32'(a_outstanding), 32'd0);
    rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
    smp(); chk("t1 rsp drained", 32'(a_rsp_valid), 32'd0);
    cyc();

    // ---- 2: tag exhaustion ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req(1'b0, 32'h100 + 32'(i * 4), 32'h0);
      smp(); chk("t2 rd req_ready", 32'(a_req_ready), 32'd1);
      cyc(); req_valid = 1'b0;
      smp(); chk("t2 rd tag", 32'(a_tlp_tag), 32'(i));
      tlp_ready = 1'b1; cyc(); tlp_ready = 1'b0;
    end
    smp(); chk("t2 outstanding 4", 32'(a_outstanding), 32'd4);
    cyc();
    req(1'b0, 32'h200, 32'h0);
    smp(); chk("t2 5th rd blocked", 32'(a_req_ready), 32'd0);
    req_write = 1'b1; req_wdata = 32'h0BADF00D;
    #1 chk("t2 wr accepted", 32'(a_req_ready), 32'd1);
    cyc(); req_valid = 1'b0;
    smp();
    chk("t2 wr type", 32'(a_tlp_type), 32'd1);
    chk("t2 wr tag", 32'(a_tlp_tag), 32'd0);
    tlp_ready = 1'b1; cyc(); tlp_ready = 1'b0;
    cpl_valid = 1'b1; cpl_tag = 8'd2; cpl_status = 3'b000; cpl_data = 32'h22;
    cyc(); cpl_valid = 1'b0;
    smp();
    chk("t2 rsp tag 2", 32'(a_rsp_tag), 32'd2);
    chk("t2 outstanding 3", 32'(a_outstanding), 32'd3);
    rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
    req(1'b0, 32'h204, 32'h0);
    smp(); chk("t2 rd after free", 32'(a_req_ready), 32'd1);
    cyc(); req_valid = 1'b0;
    smp();
    chk("t2 reuse tag 2", 32'(a_tlp_tag), 32'd2);
    chk("t2 outstanding 4 again", 32'(a_outstanding), 32'd4);
    tlp_ready = 1'b1; cyc(); tlp_ready = 1'b0;

    // ---- 3: timeout (dut_b, timeout 16) ----
    do_reset();
    req(1'b0, 32'h20, 32'h0);
    cyc(); req_valid = 1'b0;
    smp(); chk("t3 tlp_valid", 32'(b_tlp_valid), 32'd1);
    tlp_ready = 1'b1;
    cyc(); tlp_ready = 1'b0;            // handshake edge is the one just passed
    repeat (16) @(posedge clk);
    smp(); chk("t3 no rsp at 16", 32'(b_rsp_valid), 32'd0);
    @(posedge clk);
    smp();
    chk("t3 rsp at 17", 32'(b_rsp_valid), 32'd1);
    chk("t3 rsp tag", 32'(b_rsp_tag), 32'd0);
    chk("t3 rsp status", 32'(b_rsp_status), 32'd4);
    chk("t3 rsp data", b_rsp_data, 32'd0);
    chk("t3 outstanding 0", 32'(b_outstanding), 32'd0);
    #6 rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
    cpl_valid = 1'b1; cpl_tag = 8'd0; cpl_status = 3'b000; cpl_data = 32'h99;
    cyc(); cpl_valid = 1'b0;
    smp();
    chk("t3 late cpl err pulse", 32'(b_err), 32'd1);
    chk("t3 unexp_cnt 1", 32'(b_unexp_cnt), 32'd1);
    chk("t3 late cpl no rsp", 32'(b_rsp_valid), 32'd0);
    cyc();
    smp(); chk("t3 err pulse ends", 32'(b_err), 32'd0);
    cyc();

    // ---- 4: completion vs timeout collision (dut_b) ----
    do_reset();
    req(1'b0, 32'h40, 32'h0); cyc();
    req_valid = 1'b0; tlp_ready = 1'b1; cyc();        // tag 0 sent
    tlp_ready = 1'b0; req(1'b0, 32'h44, 32'h0); cyc();
    req_valid = 1'b0; tlp_ready = 1'b1; cyc();        // tag 1 sent at edge h1
    tlp_ready = 1'b0;
    cpl_valid = 1'b1; cpl_tag = 8'd0; cpl_status = 3'b000; cpl_data = 32'h1;
    cyc();                                            // h1+1: tag 0 freed
    cpl_valid = 1'b0; rsp_ready = 1'b1; req(1'b0, 32'h48, 32'h0);
    cyc();                                            // h1+2: tag 0 reallocated
    rsp_ready = 1'b0; req_valid = 1'b0;
    smp(); chk("t4 realloc tag 0", 32'(b_tlp_tag), 32'd0);
    tlp_ready = 1'b1; cyc();                          // h1+3
    tlp_ready = 1'b0;
    repeat (13) @(posedge clk);                       // h1+16: tag 1 expired this cycle
    #1 cpl_valid = 1'b1; cpl_tag = 8'd0; cpl_status = 3'b010; cpl_data = 32'h1234;
    smp();
    chk("t4 no early timeout", 32'(b_rsp_valid), 32'd0);
    chk("t4 cpl_ready", 32'(b_cpl_ready), 32'd1);
    cyc(); cpl_valid = 1'b0;
    smp();
    chk("t4 first rsp tag", 32'(b_rsp_tag), 32'd0);
    chk("t4 first rsp status", 32'(b_rsp_status), 32'd2);
    chk("t4 first rsp data", b_rsp_data, 32'h1234);
    chk("t4 outstanding 1", 32'(b_outstanding), 32'd1);
    rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
    smp();
    chk("t4 second rsp valid", 32'(b_rsp_valid), 32'd1);
    chk("t4 second rsp tag", 32'(b_rsp_tag), 32'd1);
    chk("t4 second rsp status", 32'(b_rsp_status), 32'd4);
    chk("t4 second rsp data", b_rsp_data, 32'd0);
    chk("t4 outstanding 0", 32'(b_outstanding), 32'd0);
    rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
    smp(); chk("t4 rsp drained", 32'(b_rsp_valid), 32'd0);
    cyc();

    // ---- 5: backpressure (dut_a) ----
    do_reset();
    req(1'b1, 32'h50, 32'hCAFEF00D);
    cyc();
    req(1'b0, 32'h54, 32'h0);                         // held off by the pending TLP
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("t5 tlp stable", {a_tlp_valid, a_tlp_type, a_tlp_tag[3:0], a_tlp_address[23:0]},
          {1'b1, 3'b001, 4'd0, 24'h50});
      chk("t5 tlp data stable", a_tlp_data, 32'hCAFEF00D);
      chk("t5 req_ready low", 32'(a_req_ready), 32'd0);
      cyc();
    end
    req_valid = 1'b0; tlp_ready = 1'b1; cyc(); tlp_ready = 1'b0;
    req(1'b0, 32'h54, 32'h0); cyc();
    req_valid = 1'b0; tlp_ready = 1'b1; cyc(); tlp_ready = 1'b0;
    cpl_valid = 1'b1; cpl_tag = 8'd0; cpl_status = 3'b000; cpl_data = 32'h5555AAAA;
    cyc();
    cpl_data = 32'h77777777;                          // would be unexpected if accepted
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("t5 rsp stable", {a_rsp_valid, a_rsp_tag[3:0], a_rsp_status},
          {1'b1, 4'd0, 3'b000});
      chk("t5 rsp data stable", a_rsp_data, 32'h5555AAAA);
      chk("t5 cpl_ready low", 32'(a_cpl_ready), 32'd0);
      cyc();
    end
    cpl_valid = 1'b0;
    smp(); chk("t5 no unexpected", 32'(a_unexp_cnt), 32'd0);
    cyc();

    // ---- 6: reset and link (dut_a) ----
    do_reset();
    for (int i = 0; i < 2; i++) begin
      req(1'b0, 32'h60 + 32'(i * 4), 32'h0); cyc();
      req_valid = 1'b0; tlp_ready = 1'b1; cyc(); tlp_ready = 1'b0;
    end
    smp(); chk("t6 outstanding 2", 32'(a_outstanding), 32'd2);
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    smp();
    chk("t6 outstanding 0", 32'(a_outstanding), 32'd0);
    chk("t6 tlp_valid 0", 32'(a_tlp_valid), 32'd0);
    chk("t6 tlp_address 0", a_tlp_address, 32'd0);
    chk("t6 tlp_length 0", 32'(a_tlp_length), 32'd0);
    chk("t6 rsp_valid 0", 32'(a_rsp_valid), 32'd0);
    chk("t6 unexp_cnt 0", 32'(a_unexp_cnt), 32'd0);
    cyc();
    cpl_valid = 1'b1; cpl_tag = 8'd0; cpl_status = 3'b000; cpl_data = 32'h1;
    cyc(); cpl_valid = 1'b0;
    smp();
    chk("t6 late cpl err", 32'(a_err), 32'd1);
    chk("t6 unexp_cnt 1", 32'(a_unexp_cnt), 32'd1);
    chk("t6 late cpl no rsp", 32'(a_rsp_valid), 32'd0);
    cyc();
    cpl_valid = 1'b1; cpl_tag = 8'd7;                // out-of-range tag
    cyc(); cpl_valid = 1'b0;
    smp(); chk("t6 unexp_cnt 2", 32'(a_unexp_cnt), 32'd2);
    cyc();
    link_up = 1'b0; req(1'b1, 32'h70, 32'h1);
    smp(); chk("t6 link down req_ready", 32'(a_req_ready), 32'd0);
    cyc();
    link_up = 1'b1;
    cyc(); req_valid = 1'b0; link_up = 1'b0;          // accepted, then link drops
    smp();
    chk("t6 tlp kept on link drop", 32'(a_tlp_valid), 32'd1);
    chk("t6 tlp addr kept", a_tlp_address, 32'h70);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
